// File: rtl/matrixmult_sequencer.sv
// matrixmult_sequencer
//   Time-multiplexed 4x4 matrix by 4x1 vector multiplier for the pixel
//   transform path. A 4x4 coefficient matrix and a 4-entry pixel vector are
//   loaded through a simple write port while the block is idle. A start
//   request runs 16 multiply-accumulate steps through one registered
//   multiplier and one accumulator. The block then presents four row results
//   and pulses done for one cycle.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   wr_en          operand store write strobe (honoured only while idle)
//   wr_addr[4:0]   0-15 matrix element row-major, 16-19 vector element
//   wr_data        operand write data (DATA_W, unsigned)
//   start          computation request, sampled only while idle
//   busy           high while products are being issued or flushed
//   done           one-cycle pulse when all four row results are valid
//   pixelout_0..3  row results, sum over c of M[r][c]*V[c], modulo 2^ACC_W
module matrixmult_sequencer #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  pixelout_0,
  output logic [ACC_W-1:0]  pixelout_1,
  output logic [ACC_W-1:0]  pixelout_2,
  output logic [ACC_W-1:0]  pixelout_3
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]          k_q, k_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   m_q [16];
  logic [DATA_W-1:0]   m_d [16];
  logic [DATA_W-1:0]   v_q [4];
  logic [DATA_W-1:0]   v_d [4];
  logic [ACC_W-1:0]    prod_q, prod_d;
  logic                prod_valid_q, prod_valid_d;
  logic [1:0]          prod_row_q, prod_row_d;
  logic [1:0]          prod_col_q, prod_col_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W-1:0]    pix_q [4];
  logic [ACC_W-1:0]    pix_d [4];

  logic [2*DATA_W-1:0] mul_full;
  logic [ACC_W-1:0]    acc_sum;
  logic                wr_ok;

  // Operands are widened before multiplying so the full double-width
  // product is kept regardless of context width rules.
  assign mul_full = {{DATA_W{1'b0}}, m_q[k_q]} * {{DATA_W{1'b0}}, v_q[k_q[1:0]]};

  // Column 0 starts a fresh row sum, so the previous row's total is dropped.
  assign acc_sum = (prod_col_q == 2'd0 ? '0 : acc_q) + prod_q;

  // Writes are accepted only while idle; addresses 20-31 are silently dropped.
  assign wr_ok = wr_en && (state_q == IDLE) && (wr_addr <= 5'd19);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    done_d       = 1'b0;
    m_d          = m_q;
    v_d          = v_q;
    prod_d       = prod_q;
    prod_valid_d = 1'b0;
    prod_row_d   = prod_row_q;
    prod_col_d   = prod_col_q;
    acc_d        = acc_q;
    pix_d        = pix_q;

    if (wr_ok) begin
      if (!wr_addr[4]) begin
        m_d[wr_addr[3:0]] = wr_data;
      end else begin
        v_d[wr_addr[1:0]] = wr_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          k_d     = 4'd0;
        end
      end
      ISSUE: begin
        // k walks the matrix row-major, so k[3:2] is the row and k[1:0] the column.
        prod_d       = ACC_W'(mul_full);
        prod_valid_d = 1'b1;
        prod_row_d   = k_q[3:2];
        prod_col_d   = k_q[1:0];
        k_d          = k_q + 4'd1;
        if (k_q == 4'd15) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The last product is accumulated on this same edge.
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (prod_valid_q) begin
      acc_d = acc_sum;
      if (prod_col_q == 2'd3) begin
        pix_d[prod_row_q] = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      done_q       <= 1'b0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      prod_row_q   <= '0;
      prod_col_q   <= '0;
      acc_q        <= '0;
      for (int i = 0; i < 16; i++) m_q[i] <= '0;
      for (int i = 0; i < 4; i++) v_q[i] <= '0;
      for (int i = 0; i < 4; i++) pix_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      done_q       <= done_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
      prod_row_q   <= prod_row_d;
      prod_col_q   <= prod_col_d;
      acc_q        <= acc_d;
      m_q          <= m_d;
      v_q          <= v_d;
      pix_q        <= pix_d;
    end
  end

  assign busy       = (state_q == ISSUE) || (state_q == FLUSH);
  assign done       = done_q;
  assign pixelout_0 = pix_q[0];
  assign pixelout_1 = pix_q[1];
  assign pixelout_2 = pix_q[2];
  assign pixelout_3 = pix_q[3];

endmodule

// File: tb/tb_matrixmult_sequencer.sv
// tb_matrixmult_sequencer
//   Directed bench for matrixmult_sequencer. Each accepted start pushes its
//   hand-computed row results into a queue; a monitor pops and compares them
//   whenever the design pulses done.
module tb_matrixmult_sequencer;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  typedef logic [4*ACC_W-1:0] exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  pixelout_0;
  logic [ACC_W-1:0]  pixelout_1;
  logic [ACC_W-1:0]  pixelout_2;
  logic [ACC_W-1:0]  pixelout_3;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_count  = 0;

  localparam exp_t EXP_T1 = {32'd47, 32'd23, 32'd64, 32'd16};
  localparam exp_t EXP_T2 = {4{32'hFFF80004}};
  localparam exp_t EXP_Z  = '0;

  matrixmult_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pixelout_0 (pixelout_0),
    .pixelout_1 (pixelout_1),
    .pixelout_2 (pixelout_2),
    .pixelout_3 (pixelout_3)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [ACC_W-1:0] actual,
                             input logic [ACC_W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_done: got done with no run pending, expected none");
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pixelout_0", pixelout_0, mon_e[31:0]);
        checkOutput("pixelout_1", pixelout_1, mon_e[63:32]);
        checkOutput("pixelout_2", pixelout_2, mon_e[95:64]);
        checkOutput("pixelout_3", pixelout_3, mon_e[127:96]);
        checkOutput("busy_at_done", {31'b0, busy}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeOp(input int addr, input logic [DATA_W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = 5'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic loadTest1();
    logic [DATA_W-1:0] m1 [16] = '{1, 1, 2, 3, 5, 6, 7, 3, 1, 2, 3, 2, 4, 5, 3, 5};
    logic [DATA_W-1:0] v1 [4]  = '{2, 5, 3, 1};
    for (int i = 0; i < 16; i++) writeOp(i, m1[i]);
    for (int i = 0; i < 4; i++) writeOp(16 + i, v1[i]);
  endtask

  // Issues start on edge E0 and registers the expected result.
  task automatic applyStimulus(input exp_t e);
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen, bounded.
  task automatic waitDone(input string name, output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: got no done after %0d edges, expected done", name, n);
    end
  endtask

  initial begin
    int n;
    int dc;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    #12;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_pix0", pixelout_0, 32'd0);
    checkOutput("reset_pix3", pixelout_3, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] test 1: basic matrix-vector product");
    loadTest1();
    applyStimulus(EXP_T1);
    checkOutput("t1_busy_after_start", {31'b0, busy}, 32'd1);
    waitDone("t1", n);
    checkOutput("t1_latency", n, 32'd17);
    tick();
    checkOutput("t1_done_one_cycle", {31'b0, done}, 32'd0);
    checkOutput("t1_busy_idle", {31'b0, busy}, 32'd0);

    $display("[TB] test 2: all operands at maximum, row sums wrap");
    for (int i = 0; i < 20; i++) writeOp(i, 16'hFFFF);
    applyStimulus(EXP_T2);
    waitDone("t2", n);
    checkOutput("t2_latency", n, 32'd17);
    tick();

    $display("[TB] test 3: write and start while busy are ignored");
    loadTest1();
    dc = done_count;
    applyStimulus(EXP_T1);
    tick();
    tick();
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 16'd9;
    tick();
    wr_en   = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone("t3", n);
    repeat (25) tick();
    checkOutput("t3_done_pulses", done_count - dc, 32'd1);
    applyStimulus(EXP_T1);
    waitDone("t3_rerun", n);
    tick();

    $display("[TB] test 4: start held high gives back-to-back runs");
    dc = done_count;
    exp_q.push_back(EXP_T1);
    exp_q.push_back(EXP_T1);
    start = 1'b1;
    tick();
    waitDone("t4_first", n);
    checkOutput("t4_first_latency", n, 32'd17);
    tick();
    waitDone("t4_second", n);
    start = 1'b0;
    repeat (25) tick();
    checkOutput("t4_done_pulses", done_count - dc, 32'd2);

    $display("[TB] test 5: reset mid-run aborts");
    dc = done_count;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_busy", {31'b0, busy}, 32'd0);
    checkOutput("t5_done", {31'b0, done}, 32'd0);
    checkOutput("t5_pix0", pixelout_0, 32'd0);
    checkOutput("t5_pix1", pixelout_1, 32'd0);
    checkOutput("t5_pix2", pixelout_2, 32'd0);
    checkOutput("t5_pix3", pixelout_3, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("t5_no_done", done_count - dc, 32'd0);
    applyStimulus(EXP_Z);
    waitDone("t5", n);
    tick();

    $display("[TB] test 6: writes to addresses 20-31 are dropped");
    loadTest1();
    for (int a = 20; a < 32; a++) writeOp(a, 16'hFFFF);
    applyStimulus(EXP_T1);
    waitDone("t6", n);
    repeat (5) tick();

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
